// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus encoding,
// stall masks, FSM states and the default exception vector.
package pipe_ctrl_pkg;

  localparam int          STALL_W        = 8;
  localparam logic        STOP           = 1'b1;
  localparam logic        NO_STOP        = 1'b0;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam logic [STALL_W-1:0] STALL_NONE = 8'h00;
  localparam logic [STALL_W-1:0] STALL_IF   = 8'h03;
  localparam logic [STALL_W-1:0] STALL_ID   = 8'h0F;
  localparam logic [STALL_W-1:0] STALL_EX   = 8'h1F;
  localparam logic [STALL_W-1:0] STALL_MEM  = 8'h7F;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // The deepest requesting stage wins; everything upstream of it freezes too.
  function automatic logic [STALL_W-1:0] stall_mask(input logic req_if,
                                                    input logic req_id,
                                                    input logic req_ex,
                                                    input logic req_mem);
    logic [STALL_W-1:0] mask;
    if (req_mem) begin
      mask = STALL_MEM;
    end else if (req_ex) begin
      mask = STALL_EX;
    end else if (req_id) begin
      mask = STALL_ID;
    end else if (req_if) begin
      mask = STALL_IF;
    end else begin
      mask = STALL_NONE;
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall-request, redirect-event and stall/flush bus between the pipeline
// stages and the central controller.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic               stallreq_if;
  logic               stallreq_id;
  logic               stallreq_ex;
  logic               stallreq_mem;
  logic               exc_valid;
  logic               eret;
  logic [31:0]        cp0_epc;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        new_pc;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output exc_valid, eret, cp0_epc,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  exc_valid, eret, cp0_epc,
    output stall, flush, new_pc
  );

endinterface

// File: rtl/pipe_ctrl_stall_counter.sv
// Saturating performance counter with synchronous clear; clear beats increment.
module pipe_ctrl_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // next count: clear, saturating increment or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests into the stall bus and
// sequences exception/ERET redirects (freeze, drain memory, flush, redirect).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e             state_d, state_q;
  logic [31:0]        target_d, target_q;
  logic               flush_d, flush_q;
  logic [31:0]        new_pc_d, new_pc_q;
  logic [STALL_W-1:0] stall_s;
  logic               event_s;

  assign event_s = bus.exc_valid | bus.eret;

  // next state, redirect target and combinational stall bus
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    stall_s  = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        if (event_s) begin
          // bubble the faulting instruction at MEM/WB so it never commits
          stall_s  = STALL_MEM;
          target_d = bus.exc_valid ? EXC_VECTOR : bus.cp0_epc;
          state_d  = bus.stallreq_mem ? ST_WAIT_MEM : ST_FLUSH;
        end else begin
          stall_s = stall_mask(bus.stallreq_if, bus.stallreq_id,
                               bus.stallreq_ex, bus.stallreq_mem);
          state_d = ST_RUN;
        end
      end
      ST_WAIT_MEM: begin
        stall_s = STALL_MEM;
        if (bus.stallreq_mem) begin
          state_d = ST_WAIT_MEM;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        stall_s = STALL_NONE;
        state_d = ST_RUN;
      end
      default: begin
        stall_s = STALL_NONE;
        state_d = ST_RUN;
      end
    endcase
    flush_d  = (state_d == ST_FLUSH);
    new_pc_d = flush_d ? target_d : ZERO_WORD;
  end

  // state, latched target and registered flush/redirect outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      target_q <= ZERO_WORD;
      flush_q  <= 1'b0;
      new_pc_q <= ZERO_WORD;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign bus.stall  = rst ? STALL_NONE : stall_s;
  assign bus.flush  = flush_q;
  assign bus.new_pc = new_pc_q;

  pipe_ctrl_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (bus.stall != STALL_NONE),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall masks, redirect
// sequencing, reset abort and the saturating stall counter.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        perf_clr;
  logic [31:0] stall_cnt;
  logic        perf_clr2;
  logic [3:0]  stall_cnt2;

  int n_checks;
  int n_fail;

  pipe_ctrl_if bus();
  pipe_ctrl_if bus2();

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .perf_clr  (perf_clr),
    .stall_cnt (stall_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .perf_clr  (perf_clr2),
    .stall_cnt (stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.exc_valid    = 1'b0;
    bus.eret         = 1'b0;
    bus.cp0_epc      = 32'h0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    perf_clr = 1'b0;
    perf_clr2 = 1'b0;
    idle_inputs();
    bus2.stallreq_if  = 1'b0;
    bus2.stallreq_id  = 1'b0;
    bus2.stallreq_ex  = 1'b0;
    bus2.stallreq_mem = 1'b0;
    bus2.exc_valid    = 1'b0;
    bus2.eret         = 1'b0;
    bus2.cp0_epc      = 32'h0;

    cyc(); cyc();
    smp();
    chk("rst_stall", {24'h0, bus.stall}, 32'h0);
    chk("rst_flush", {31'h0, bus.flush}, 32'h0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    chk("rst_cnt", stall_cnt, 32'h0);

    // single and combined stall requests
    cyc(); rst = 1'b0; bus.stallreq_id = 1'b1;
    smp(); chk("mask_id", {24'h0, bus.stall}, 32'h0F);
    cyc(); idle_inputs(); bus.stallreq_if = 1'b1; bus.stallreq_ex = 1'b1;
    smp(); chk("mask_if_ex", {24'h0, bus.stall}, 32'h1F);
    chk("mask_no_flush", {31'h0, bus.flush}, 32'h0);
    cyc(); idle_inputs(); bus.stallreq_mem = 1'b1;
    smp(); chk("mask_mem", {24'h0, bus.stall}, 32'h7F);
    cyc(); idle_inputs();
    smp(); chk("mask_none", {24'h0, bus.stall}, 32'h00);
    chk("mask_no_flush2", {31'h0, bus.flush}, 32'h0);
    chk("cnt_after_3", stall_cnt, 32'd3);

    // exception with memory idle: flush at N+1
    cyc(); bus.exc_valid = 1'b1;
    smp(); chk("exc_n_stall", {24'h0, bus.stall}, 32'h7F);
    chk("exc_n_flush", {31'h0, bus.flush}, 32'h0);
    cyc(); idle_inputs();
    smp(); chk("exc_n1_flush", {31'h0, bus.flush}, 32'h1);
    chk("exc_n1_pc", bus.new_pc, 32'hBFC0_0380);
    chk("exc_n1_stall", {24'h0, bus.stall}, 32'h00);
    cyc(); bus.stallreq_id = 1'b1;
    smp(); chk("exc_n2_flush", {31'h0, bus.flush}, 32'h0);
    chk("exc_n2_pc", bus.new_pc, 32'h0);
    chk("exc_n2_run", {24'h0, bus.stall}, 32'h0F);

    // ERET while memory busy for N, N+1; memory drops at N+2 -> flush at N+3
    cyc(); idle_inputs(); bus.eret = 1'b1; bus.cp0_epc = 32'h8000_1234; bus.stallreq_mem = 1'b1;
    smp(); chk("eret_n_stall", {24'h0, bus.stall}, 32'h7F);
    cyc(); bus.eret = 1'b0; bus.cp0_epc = 32'h0;
    smp(); chk("eret_n1_stall", {24'h0, bus.stall}, 32'h7F);
    chk("eret_n1_flush", {31'h0, bus.flush}, 32'h0);
    cyc(); bus.stallreq_mem = 1'b0;
    smp(); chk("eret_n2_stall", {24'h0, bus.stall}, 32'h7F);
    chk("eret_n2_flush", {31'h0, bus.flush}, 32'h0);
    cyc();
    smp(); chk("eret_n3_flush", {31'h0, bus.flush}, 32'h1);
    chk("eret_n3_pc", bus.new_pc, 32'h8000_1234);
    chk("eret_n3_stall", {24'h0, bus.stall}, 32'h00);
    cyc();
    smp(); chk("eret_n4_flush", {31'h0, bus.flush}, 32'h0);

    // simultaneous exception and ERET, plus a second exception while waiting
    cyc(); bus.exc_valid = 1'b1; bus.eret = 1'b1; bus.cp0_epc = 32'h8000_0010; bus.stallreq_mem = 1'b1;
    smp(); chk("both_n_stall", {24'h0, bus.stall}, 32'h7F);
    cyc(); bus.eret = 1'b0;
    smp(); chk("both_n1_flush", {31'h0, bus.flush}, 32'h0);
    cyc(); idle_inputs();
    smp(); chk("both_n2_stall", {24'h0, bus.stall}, 32'h7F);
    cyc();
    smp(); chk("both_n3_flush", {31'h0, bus.flush}, 32'h1);
    chk("both_n3_pc", bus.new_pc, 32'hBFC0_0380);
    cyc();
    smp(); chk("both_n4_flush", {31'h0, bus.flush}, 32'h0);
    cyc();
    smp(); chk("both_n5_flush", {31'h0, bus.flush}, 32'h0);

    // reset while in WAIT_MEM aborts the redirect
    cyc(); bus.exc_valid = 1'b1; bus.stallreq_mem = 1'b1;
    cyc(); bus.exc_valid = 1'b0; rst = 1'b1;
    smp(); chk("rstw_in_stall", {24'h0, bus.stall}, 32'h00);
    cyc(); rst = 1'b0; bus.stallreq_mem = 1'b0;
    smp(); chk("rstw_stall", {24'h0, bus.stall}, 32'h00);
    chk("rstw_flush", {31'h0, bus.flush}, 32'h0);
    chk("rstw_cnt", stall_cnt, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp(); chk("rstw_no_flush", {31'h0, bus.flush}, 32'h0);
      chk("rstw_no_pc", bus.new_pc, 32'h0);
    end

    // counter: five stalled cycles, then clear with a concurrent stall
    cyc(); bus.stallreq_id = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    cyc(); bus.stallreq_id = 1'b0;
    smp(); chk("cnt_5", stall_cnt, 32'd5);
    cyc(); bus.stallreq_id = 1'b1; perf_clr = 1'b1;
    cyc(); bus.stallreq_id = 1'b0; perf_clr = 1'b0;
    smp(); chk("cnt_clr", stall_cnt, 32'd0);

    // 4-bit counter saturates after 15 stalled cycles
    cyc(); bus2.stallreq_ex = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      if (j == 20) bus2.stallreq_ex = 1'b0;
      smp();
      if (j == 14) chk("cnt4_14", {28'h0, stall_cnt2}, 32'hE);
    end
    chk("cnt4_sat", {28'h0, stall_cnt2}, 32'hF);
    cyc();
    smp(); chk("cnt4_hold", {28'h0, stall_cnt2}, 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
